// File: rtl/lcd_seq.sv
// rtl/lcd_seq.sv - LCD power-up/init command sequencer with host write pass-through
//
// Purpose: waits out the LCD power-up delay and then feeds a fixed init
// command ROM into the LCD bus-cycle engine. Some commands are followed by an
// extra settle delay. Once the ROM is exhausted, words from the host write
// source are forwarded. A one-deep output entry register decouples the
// sources from the bus-cycle engine.
//
// Ports:
//   clk_i        in   system clock
//   rst_i        in   asynchronous, active-high reset
//   init_i       in   re-initialise request (single-cycle pulse)
//   busy_o       out  power-up wait / init sequence in progress (registered)
//   host_rsn_i   in   host word type: 1=command, 0=data/address
//   host_data_i  in   host word
//   host_rdy_i   in   host source has a word available
//   host_rd_o    out  one-cycle pop pulse to the host source
//   lcd_rsn_o    out  held entry type to the bus-cycle engine
//   lcd_data_o   out  held entry data to the bus-cycle engine
//   lcd_rdy_o    out  held entry valid
//   lcd_rd_i     in   one-cycle read pulse from the bus-cycle engine
//
// Build option: define LCD_SEQ_CURSOR_EN to turn the cursor and blink on
// (ROM entry 3 = 0x0F instead of 0x0C).
module lcd_seq #(
  parameter real CLK_HZ = 160000000.0,
  parameter int  PWR_US = 50000,
  parameter int  GAP_US = 5000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       init_i,
  output logic       busy_o,
  input  logic       host_rsn_i,
  input  logic [7:0] host_data_i,
  input  logic       host_rdy_i,
  output logic       host_rd_o,
  output logic       lcd_rsn_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rdy_o,
  input  logic       lcd_rd_i
);

  // Delays in clocks, rounded to nearest.
  localparam int PWR_CNT = $rtoi(real'(PWR_US) * CLK_HZ / 1.0e6 + 0.5);
  localparam int GAP_CNT = $rtoi(real'(GAP_US) * CLK_HZ / 1.0e6 + 0.5);
  localparam int MAX_CNT = (PWR_CNT > GAP_CNT) ? PWR_CNT : GAP_CNT;
  localparam int CNT_W   = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;
  localparam logic [2:0] LAST_IDX = 3'd5;

  typedef enum logic [1:0] {st_pwr, st_init, st_gap, st_run} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             valid_q, valid_d;
  logic             rsn_q, rsn_d;
  logic [7:0]       data_q, data_d;
  logic             host_rd_q, host_rd_d;
  logic             busy_q, busy_d;

  logic [7:0] rom_data;
  logic       rom_gap;
  logic       restart;
  logic       can_load;
  logic       consume;

  always_comb begin
    rom_data = 8'h00;
    rom_gap  = 1'b0;
    case (idx_q)
      3'd0: begin rom_data = 8'h33; rom_gap = 1'b1; end
      3'd1: begin rom_data = 8'h32; rom_gap = 1'b1; end
      3'd2: rom_data = 8'h28;
`ifdef LCD_SEQ_CURSOR_EN
      3'd3: rom_data = 8'h0F;
`else
      3'd3: rom_data = 8'h0C;
`endif
      3'd4: rom_data = 8'h01;
      3'd5: rom_data = 8'h06;
      default: rom_data = 8'h00;
    endcase
  end

  // A pending re-init waits until the held entry has been delivered, and
  // takes priority over loading anything new in that cycle.
  assign restart  = pending_q && !valid_q && (state_q != st_pwr);
  assign can_load = !valid_q && !lcd_rd_i && !restart;
  assign consume  = valid_q && lcd_rd_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pending_d = pending_q | init_i;
    valid_d   = valid_q;
    rsn_d     = rsn_q;
    data_d    = data_q;
    host_rd_d = 1'b0;

    if (consume) valid_d = 1'b0;

    case (state_q)
      st_pwr: begin
        // The fresh sequence started here already satisfies any request
        // that arrived during power-up.
        if (int'(cnt_q) + 1 >= PWR_CNT) begin
          state_d   = st_init;
          cnt_d     = '0;
          idx_d     = '0;
          pending_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      st_init: begin
        if (consume) begin
          if (idx_q == LAST_IDX) begin
            state_d = st_run;
          end else begin
            idx_d = idx_q + 3'd1;
            if (rom_gap) begin
              state_d = st_gap;
              cnt_d   = '0;
            end
          end
        end
        if (can_load) begin
          valid_d = 1'b1;
          rsn_d   = 1'b1;
          data_d  = rom_data;
        end
      end
      st_gap: begin
        if (int'(cnt_q) + 1 >= GAP_CNT) begin
          state_d = st_init;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      st_run: begin
        // host_rd_q blocks the cycle in which the source is still popping.
        if (can_load && host_rdy_i && !host_rd_q) begin
          valid_d   = 1'b1;
          rsn_d     = host_rsn_i;
          data_d    = host_data_i;
          host_rd_d = 1'b1;
        end
      end
      default: state_d = st_pwr;
    endcase

    if (restart) begin
      state_d   = st_init;
      idx_d     = '0;
      cnt_d     = '0;
      pending_d = init_i;
    end

    busy_d = (state_d != st_run) || pending_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= st_pwr;
      cnt_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      rsn_q     <= 1'b0;
      data_q    <= 8'h00;
      host_rd_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      rsn_q     <= rsn_d;
      data_q    <= data_d;
      host_rd_q <= host_rd_d;
      busy_q    <= busy_d;
    end
  end

  assign lcd_rdy_o  = valid_q;
  assign lcd_rsn_o  = rsn_q;
  assign lcd_data_o = data_q;
  assign host_rd_o  = host_rd_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_lcd_seq.sv
// tb/tb_lcd_seq.sv - self-checking bench for lcd_seq
`timescale 1ns/1ps
module tb_lcd_seq;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       init_i;
  logic       busy_o;
  logic       host_rsn_i;
  logic [7:0] host_data_i;
  logic       host_rdy_i;
  logic       host_rd_o;
  logic       lcd_rsn_o;
  logic [7:0] lcd_data_o;
  logic       lcd_rdy_o;
  logic       lcd_rd_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Consumed-entry log, written only by the environment process.
  logic [8:0] log_ent [0:63];
  int         rd_cyc  [0:63];
  int         rise_cyc[0:63];
  int         log_n = 0;
  int         busy_fall_cyc = 0;
  int         pop_n = 0;
  int         pop_busy_n = 0;

  // Host source contents, written only by the test process.
  logic       fifo_rsn [0:15];
  logic [7:0] fifo_data[0:15];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  int init_req_n = 0, init_done_n = 0;
  int last_req_n = 0, last_done_n = 0;
  bit resp_en = 1'b1;
  bit hold_28 = 1'b0;

  logic [8:0] rom_exp[0:5];

  lcd_seq #(
    .CLK_HZ(10.0e6),
    .PWR_US(10),
    .GAP_US(5)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .init_i     (init_i),
    .busy_o     (busy_o),
    .host_rsn_i (host_rsn_i),
    .host_data_i(host_data_i),
    .host_rdy_i (host_rdy_i),
    .host_rd_o  (host_rd_o),
    .lcd_rsn_o  (lcd_rsn_o),
    .lcd_data_o (lcd_data_o),
    .lcd_rdy_o  (lcd_rdy_o),
    .lcd_rd_i   (lcd_rd_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Environment: bus-cycle engine model (read 3 cycles after ready rises),
  // host source model, and init pulse generator. Acts on the falling edge.
  initial begin : env
    int age;
    bit prev_rdy;
    bit prev_busy;
    age = 0; prev_rdy = 1'b0; prev_busy = 1'b1;
    lcd_rd_i = 1'b0; init_i = 1'b0;
    host_rdy_i = 1'b0; host_rsn_i = 1'b0; host_data_i = 8'h00;
    forever begin
      @(negedge clk_i);
      lcd_rd_i = 1'b0;
      init_i   = 1'b0;
      if (init_done_n != init_req_n) begin
        init_i = 1'b1;
        init_done_n++;
      end
      if (host_rd_o === 1'b1) begin
        pop_n++;
        if (busy_o !== 1'b0) pop_busy_n++;
        if (rd_ptr != wr_ptr) rd_ptr++;
      end
      host_rdy_i  = (rd_ptr != wr_ptr);
      host_rsn_i  = fifo_rsn[rd_ptr];
      host_data_i = fifo_data[rd_ptr];
      if (prev_busy && busy_o === 1'b0) busy_fall_cyc = cyc;
      prev_busy = (busy_o !== 1'b0);
      if (lcd_rdy_o === 1'b1 && !prev_rdy) rise_cyc[log_n] = cyc;
      prev_rdy = (lcd_rdy_o === 1'b1);
      age = prev_rdy ? age + 1 : 0;
      if (prev_rdy && age >= 3 && resp_en && !(hold_28 && lcd_data_o === 8'h28) && log_n < 64) begin
        lcd_rd_i        = 1'b1;
        log_ent[log_n]  = {lcd_rsn_o, lcd_data_o};
        rd_cyc[log_n]   = cyc;
        if ({lcd_rsn_o, lcd_data_o} === 9'h106 && last_done_n != last_req_n) begin
          init_i = 1'b1;
          last_done_n++;
        end
        log_n++;
      end
    end
  end

  task automatic push(input logic rsn, input logic [7:0] data);
    fifo_rsn[wr_ptr]  = rsn;
    fifo_data[wr_ptr] = data;
    wr_ptr++;
  endtask

  task automatic wait_entries(input int n, input int max_cyc, output bit ok);
    int k;
    k = 0;
    while (log_n < n && k < max_cyc) begin
      @(negedge clk_i);
      k++;
    end
    ok = (log_n >= n);
  endtask

  task automatic wait_init_taken();
    int k;
    k = 0;
    while (init_done_n != init_req_n && k < 10) begin
      @(negedge clk_i);
      k++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (lcd_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", lcd_rdy_o); end
    checks++; if (lcd_rsn_o !== 1'b0) begin errors++; $display("FAIL reset_rsn: got %b want 0", lcd_rsn_o); end
    checks++; if (lcd_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", lcd_data_o); end
    checks++; if (host_rd_o !== 1'b0) begin errors++; $display("FAIL reset_host_rd: got %b want 0", host_rd_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy_o); end
  endtask

  // Power-up wait, full init sequence with gaps, host words held off until
  // not busy, init_i during power-up ignored.
  task automatic test_power_up();
    logic [8:0] exp[0:8];
    int t0, base, pop0;
    bit ok;
    for (int i = 0; i < 6; i++) exp[i] = rom_exp[i];
    exp[6] = 9'h041; exp[7] = 9'h042; exp[8] = 9'h180;
    push(1'b0, 8'h41); push(1'b0, 8'h42); push(1'b1, 8'h80);
    base = log_n; pop0 = pop_n;
    @(negedge clk_i);
    rst_i = 1'b0;
    t0 = cyc;
    repeat (20) @(negedge clk_i);
    init_req_n++;
    wait_entries(base + 9, 1500, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pwr_timeout: entries=%0d want %0d", log_n - base, 9); end
    checks++;
    if (rise_cyc[base] - t0 < 100 || rise_cyc[base] - t0 > 101) begin
      errors++; $display("FAIL pwr_delay: first ready after %0d clocks want 100..101", rise_cyc[base] - t0);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (log_ent[base + i] !== exp[i]) begin
        errors++; $display("FAIL pwr_entry%0d: got %h want %h", i, log_ent[base + i], exp[i]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rise_cyc[base + k + 1] - rd_cyc[base + k] < 50 || rise_cyc[base + k + 1] - rd_cyc[base + k] > 60) begin
        errors++; $display("FAIL pwr_gap%0d: got %0d clocks want 50..60", k, rise_cyc[base + k + 1] - rd_cyc[base + k]);
      end
    end
    checks++;
    if (busy_fall_cyc - rd_cyc[base + 5] < 1 || busy_fall_cyc - rd_cyc[base + 5] > 2) begin
      errors++; $display("FAIL pwr_busy_fall: got %0d clocks after last read want 1..2", busy_fall_cyc - rd_cyc[base + 5]);
    end
    repeat (200) @(negedge clk_i);
    checks++; if (pop_n - pop0 != 3) begin errors++; $display("FAIL pwr_pops: got %0d want 3", pop_n - pop0); end
    checks++; if (pop_busy_n != 0) begin errors++; $display("FAIL pwr_pop_busy: got %0d want 0", pop_busy_n); end
    checks++; if (log_n - base != 9) begin errors++; $display("FAIL pwr_one_seq: entries=%0d want 9", log_n - base); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL pwr_idle_busy: got %b want 0", busy_o); end
  endtask

  // Re-init while a host word is held: word delivered first, no power-up wait.
  task automatic test_init_while_held();
    int base, k;
    bit ok;
    resp_en = 1'b0;
    push(1'b0, 8'h55);
    k = 0;
    while (lcd_rdy_o !== 1'b1 && k < 100) begin @(negedge clk_i); k++; end
    checks++; if ({lcd_rsn_o, lcd_data_o} !== 9'h055) begin errors++; $display("FAIL held_word: got %h want 055", {lcd_rsn_o, lcd_data_o}); end
    init_req_n++;
    wait_init_taken();
    @(posedge clk_i); #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL held_busy: got %b want 1", busy_o); end
    checks++;
    if ({lcd_rdy_o, lcd_rsn_o, lcd_data_o} !== 10'h255) begin
      errors++; $display("FAIL held_intact: got %h want 255", {lcd_rdy_o, lcd_rsn_o, lcd_data_o});
    end
    @(negedge clk_i);
    base = log_n;
    resp_en = 1'b1;
    wait_entries(base + 7, 1500, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL held_timeout: entries=%0d want 7", log_n - base); end
    checks++; if (log_ent[base] !== 9'h055) begin errors++; $display("FAIL held_first: got %h want 055", log_ent[base]); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_ent[base + 1 + i] !== rom_exp[i]) begin
        errors++; $display("FAIL held_rom%0d: got %h want %h", i, log_ent[base + 1 + i], rom_exp[i]);
      end
    end
    checks++;
    if (rise_cyc[base + 1] - rd_cyc[base] >= 20) begin
      errors++; $display("FAIL held_no_pwr_wait: got %0d clocks want <20", rise_cyc[base + 1] - rd_cyc[base]);
    end
    k = 0;
    while (busy_o !== 1'b0 && k < 50) begin @(negedge clk_i); k++; end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL held_busy_end: got %b want 0", busy_o); end
  endtask

  // Re-init coincident with the last ROM entry being read: restart, not run.
  task automatic test_init_on_last();
    int base;
    bit ok;
    base = log_n;
    last_req_n++;
    init_req_n++;
    wait_init_taken();
    push(1'b0, 8'h99);
    wait_entries(base + 13, 2500, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL last_timeout: entries=%0d want 13", log_n - base); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (log_ent[base + i] !== rom_exp[i % 6]) begin
        errors++; $display("FAIL last_rom%0d: got %h want %h", i, log_ent[base + i], rom_exp[i % 6]);
      end
    end
    checks++; if (log_ent[base + 12] !== 9'h099) begin errors++; $display("FAIL last_host: got %h want 099", log_ent[base + 12]); end
    checks++; if (pop_busy_n != 0) begin errors++; $display("FAIL last_pop_busy: got %0d want 0", pop_busy_n); end
  endtask

  // Reset while 0x28 is held: entry dropped, full power-up wait, restart at 0x33.
  task automatic test_reset_mid_transfer();
    int base, t0, k;
    bit ok;
    hold_28 = 1'b1;
    init_req_n++;
    k = 0;
    while (!(lcd_rdy_o === 1'b1 && lcd_data_o === 8'h28) && k < 1000) begin @(negedge clk_i); k++; end
    checks++; if (k >= 1000) begin errors++; $display("FAIL rstmid_hold: 28 not held, data=%h rdy=%b", lcd_data_o, lcd_rdy_o); end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (lcd_rdy_o !== 1'b0) begin errors++; $display("FAIL rstmid_rdy: got %b want 0", lcd_rdy_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b want 1", busy_o); end
    @(negedge clk_i);
    hold_28 = 1'b0;
    base = log_n;
    rst_i = 1'b0;
    t0 = cyc;
    wait_entries(base + 6, 1500, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_timeout: entries=%0d want 6", log_n - base); end
    checks++;
    if (rise_cyc[base] - t0 < 100 || rise_cyc[base] - t0 > 101) begin
      errors++; $display("FAIL rstmid_delay: first ready after %0d clocks want 100..101", rise_cyc[base] - t0);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_ent[base + i] !== rom_exp[i]) begin
        errors++; $display("FAIL rstmid_rom%0d: got %h want %h", i, log_ent[base + i], rom_exp[i]);
      end
    end
  endtask

  initial begin : main
    rom_exp[0] = 9'h133;
    rom_exp[1] = 9'h132;
    rom_exp[2] = 9'h128;
`ifdef LCD_SEQ_CURSOR_EN
    rom_exp[3] = 9'h10F;
`else
    rom_exp[3] = 9'h10C;
`endif
    rom_exp[4] = 9'h101;
    rom_exp[5] = 9'h106;
    rst_i = 1'b1;
    test_reset();
    test_power_up();
    test_init_while_held();
    test_init_on_last();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
